transformer_ahb_host: RTL and testbench

- AHB-Lite slave that owns the initiator side of the transformer_top start/done handshake.
- Software writes operand and weight registers, then sets GO. The block soft-resets the engine, pulses eng_start and waits for eng_done with a timeout.
- On completion it captures eng_output_data, records the cycle count and raises a sticky status bit and an optional interrupt.
- Sits between the system AHB-Lite bus and one transformer_top instance.

---
 rtl/transformer_ahb_host.sv | 204 ++++++++++++++++++++
 tb/tb_transformer_ahb_host.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/transformer_ahb_host.sv
// AHB-Lite slave owning the transformer_top start/done handshake: operand registers, job FSM with timeout.
// Zero wait state, registered read data; the engine is soft-reset before each job and after an abort or timeout.
module transformer_ahb_host #(
   parameter int IDIM        = 4,
   parameter int WIDTH       = 2,
   parameter int HIDDEN_DIM  = 4,
   parameter int ERST_CYCLES = 2,
   localparam int V = IDIM*WIDTH,
   localparam int W = IDIM*HIDDEN_DIM*WIDTH,
   localparam int H = HIDDEN_DIM*WIDTH
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          hsel,
   input  logic [31:0]   haddr,
   input  logic [1:0]    htrans,
   input  logic          hwrite,
   input  logic [31:0]   hwdata,
   input  logic          hready,
   output logic          hreadyout,
   output logic          hresp,
   output logic [31:0]   hrdata,
   output logic          irq,
   output logic          eng_rst_n,
   output logic          eng_start,
   input  logic          eng_done,
   input  logic [V-1:0]  eng_output_data,
   output logic [V-1:0]  eng_input_data,
   output logic [V-1:0]  eng_encoder_output,
   output logic [V-1:0]  eng_mask,
   output logic [W-1:0]  eng_weights1,
   output logic [W-1:0]  eng_weights2,
   output logic [H-1:0]  eng_bias1,
   output logic [V-1:0]  eng_bias2
);

   typedef enum logic [2:0] {S_IDLE, S_ERST, S_START, S_WAIT, S_ABRT} state_t;

   localparam logic [7:0] ERST_LAST = 8'(ERST_CYCLES - 1);

   state_t        state, state_d;
   logic          eng_start_d, eng_rst_n_d;
   logic          a_vld, a_wr;
   logic [3:0]    a_sel;
   logic          wr_en, wr_ctrl, go_wr, abort_wr, stat_w1c;
   logic          busy, cnt_last, done_evt, to_evt, go_evt;
   logic          irq_en, done_q, to_q;
   logic [7:0]    erst_cnt;
   logic [15:0]   cnt, tlimit, cycles_q;
   logic [V-1:0]  result_q;
   logic [31:0]   rd_mux;
   logic          unused_bits;

   assign unused_bits = ^{haddr[31:6], haddr[1:0], htrans[0]};

   assign hreadyout = 1'b1;
   assign hresp     = 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_vld <= 1'b0;
         a_wr  <= 1'b0;
         a_sel <= 4'd0;
      end else if (hready) begin
         a_vld <= hsel & htrans[1];
         a_wr  <= hwrite;
         a_sel <= haddr[5:2];
      end
   end

   assign wr_en    = a_vld & a_wr;
   assign wr_ctrl  = wr_en && (a_sel == 4'd0);
   assign go_wr    = wr_ctrl & hwdata[0];
   assign abort_wr = wr_ctrl & hwdata[2];
   assign stat_w1c = wr_en && (a_sel == 4'd1);

   assign busy     = (state == S_ERST) || (state == S_START) || (state == S_WAIT);
   assign cnt_last = (tlimit != 16'd0) && (cnt == tlimit - 16'd1);
   assign done_evt = (state == S_WAIT) && eng_done;
   assign to_evt   = (state == S_WAIT) && !eng_done && cnt_last;
   assign go_evt   = (state == S_IDLE) && go_wr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         eng_start <= 1'b0;
         eng_rst_n <= 1'b0;
      end else begin
         state     <= state_d;
         eng_start <= eng_start_d;
         eng_rst_n <= eng_rst_n_d;
      end
   end

   // done outranks both timeout and abort in the same WAIT cycle
   always_comb begin
      state_d = state;
      case (state)
         S_IDLE:  if (go_wr) state_d = S_ERST;
         S_ERST:  if (erst_cnt == ERST_LAST) state_d = S_START;
         S_START: state_d = S_WAIT;
         S_WAIT: begin
            if (eng_done)       state_d = S_IDLE;
            else if (cnt_last)  state_d = S_ABRT;
            else if (abort_wr)  state_d = S_ABRT;
         end
         S_ABRT:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      eng_start_d = (state_d == S_START);
      eng_rst_n_d = !((state_d == S_ERST) || (state_d == S_ABRT));
   end

   // cnt is 0 during START so it equals cycles elapsed since eng_start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         erst_cnt <= 8'd0;
         cnt      <= 16'd0;
      end else begin
         erst_cnt <= (state == S_ERST) ? erst_cnt + 8'd1 : 8'd0;
         if (state == S_ERST)
            cnt <= 16'd0;
         else if (((state == S_START) || (state == S_WAIT)) && (cnt != 16'hFFFF))
            cnt <= cnt + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_en   <= 1'b0;
         done_q   <= 1'b0;
         to_q     <= 1'b0;
         result_q <= '0;
         cycles_q <= 16'd0;
         tlimit   <= 16'h0100;
      end else begin
         if (wr_ctrl) irq_en <= hwdata[1];
         if (done_evt)                  done_q <= 1'b1;
         else if (go_evt)               done_q <= 1'b0;
         else if (stat_w1c & hwdata[1]) done_q <= 1'b0;
         if (to_evt)                    to_q <= 1'b1;
         else if (go_evt)               to_q <= 1'b0;
         else if (stat_w1c & hwdata[2]) to_q <= 1'b0;
         if (done_evt) begin
            result_q <= eng_output_data;
            cycles_q <= cnt;
         end
         if (wr_en && (a_sel == 4'd10)) tlimit <= hwdata[15:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eng_input_data     <= '0;
         eng_encoder_output <= '0;
         eng_mask           <= '0;
         eng_weights1       <= '0;
         eng_bias1          <= '0;
         eng_weights2       <= '0;
         eng_bias2          <= '0;
      end else if (wr_en && !busy) begin
         case (a_sel)
            4'd2: eng_input_data     <= hwdata[V-1:0];
            4'd3: eng_encoder_output <= hwdata[V-1:0];
            4'd4: eng_mask           <= hwdata[V-1:0];
            4'd5: eng_weights1       <= hwdata[W-1:0];
            4'd6: eng_bias1          <= hwdata[H-1:0];
            4'd7: eng_weights2       <= hwdata[W-1:0];
            4'd8: eng_bias2          <= hwdata[V-1:0];
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_mux = '0;
      case (haddr[5:2])
         4'd0:  rd_mux[1]       = irq_en;
         4'd1:  rd_mux[2:0]     = {to_q, done_q, busy};
         4'd2:  rd_mux[V-1:0]   = eng_input_data;
         4'd3:  rd_mux[V-1:0]   = eng_encoder_output;
         4'd4:  rd_mux[V-1:0]   = eng_mask;
         4'd5:  rd_mux[W-1:0]   = eng_weights1;
         4'd6:  rd_mux[H-1:0]   = eng_bias1;
         4'd7:  rd_mux[W-1:0]   = eng_weights2;
         4'd8:  rd_mux[V-1:0]   = eng_bias2;
         4'd9:  rd_mux[V-1:0]   = result_q;
         4'd10: rd_mux[15:0]    = tlimit;
         4'd11: rd_mux[15:0]    = cycles_q;
         default: ;
      endcase
   end

   // read data is captured at the end of the address phase so it is stable for the whole data phase
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         hrdata <= 32'd0;
      else if (hready && hsel && htrans[1] && !hwrite)
         hrdata <= rd_mux;
   end

   assign irq = (done_q | to_q) & irq_en;

endmodule

// File: tb/tb_transformer_ahb_host.sv
// Randomized scoreboard bench for transformer_ahb_host with a behavioural engine and register model.
module tb_transformer_ahb_host;
   localparam int V = 8, W = 32, H = 8, ERST = 2;

   logic clk, rst_n, hsel, hwrite, hready, hreadyout, hresp, irq;
   logic [31:0] haddr, hwdata, hrdata;
   logic [1:0] htrans;
   logic eng_rst_n, eng_start, eng_done;
   logic [V-1:0] eng_output_data, eng_input_data, eng_encoder_output, eng_mask, eng_bias2;
   logic [W-1:0] eng_weights1, eng_weights2;
   logic [H-1:0] eng_bias1;

   transformer_ahb_host #(.IDIM(4), .WIDTH(2), .HIDDEN_DIM(4), .ERST_CYCLES(ERST)) dut (
      .clk(clk), .rst_n(rst_n), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
      .hwdata(hwdata), .hready(hready), .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
      .irq(irq), .eng_rst_n(eng_rst_n), .eng_start(eng_start), .eng_done(eng_done),
      .eng_output_data(eng_output_data), .eng_input_data(eng_input_data),
      .eng_encoder_output(eng_encoder_output), .eng_mask(eng_mask),
      .eng_weights1(eng_weights1), .eng_weights2(eng_weights2),
      .eng_bias1(eng_bias1), .eng_bias2(eng_bias2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   logic [31:0] q_exp[$];
   string       q_nm[$];

   // register model
   logic [31:0] m_reg [16];
   logic m_irq_en, m_done, m_to;
   logic [31:0] m_result, m_cycles;

   // engine model state
   int cyc = 0, rst_low_cnt = 0, start_cnt = 0, start_cyc = 0, irq_cyc = -1;
   int eng_delay = -1, k = 0;
   logic [7:0] eng_val = 8'h0;
   bit running = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] wmask(input int idx);
      case (idx)
         2, 3, 4, 8: return 32'((64'd1 << V) - 64'd1);
         6:          return 32'((64'd1 << H) - 64'd1);
         5, 7:       return 32'((64'd1 << W) - 64'd1);
         10:         return 32'h0000_FFFF;
         default:    return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] exp_read(input int idx);
      case (idx)
         0:       return {30'b0, m_irq_en, 1'b0};
         1:       return {29'b0, m_to, m_done, 1'b0};
         9:       return m_result;
         11:      return m_cycles;
         2, 3, 4, 5, 6, 7, 8, 10: return m_reg[idx];
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_reg[i] = 32'h0;
      m_reg[10] = 32'h0100;
      m_irq_en = 0; m_done = 0; m_to = 0; m_result = 0; m_cycles = 0;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      hsel = 1; htrans = 2'b10; hwrite = 1; haddr = a;
      @(negedge clk);
      hsel = 0; htrans = 2'b00; hwrite = 0; hwdata = d;
   endtask

   task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string nm);
      @(negedge clk);
      hsel = 1; htrans = 2'b10; hwrite = 0; haddr = a;
      q_exp.push_back(exp); q_nm.push_back(nm);
      @(negedge clk);
      hsel = 0; htrans = 2'b00;
   endtask

   // write while idle, keeping the model in step
   task automatic reg_write(input int idx, input logic [31:0] d);
      bus_write(32'(idx * 4), d);
      if (idx == 0) m_irq_en = d[1];
      else if (idx == 1) begin
         if (d[1]) m_done = 0;
         if (d[2]) m_to = 0;
      end else if ((idx >= 2 && idx <= 8) || idx == 10) m_reg[idx] = d & wmask(idx);
   endtask

   task automatic wait_start(output bit ok);
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (eng_start) begin ok = 1; break; end
      end
   endtask

   task automatic run_job(input int d, input logic [7:0] o, input string tag);
      int r0, s0, lim;
      bit exp_done;
      lim = int'(m_reg[10]);
      eng_delay = d; eng_val = o;
      r0 = rst_low_cnt; s0 = start_cnt; irq_cyc = -1;
      bus_write(32'h0, {30'b0, m_irq_en, 1'b1});
      m_done = 0; m_to = 0;
      repeat (40) @(negedge clk);
      exp_done = (d >= 1) && (lim == 0 || d < lim);
      if (exp_done) begin
         m_done = 1; m_result = 32'(o); m_cycles = 32'(d);
      end else m_to = 1;
      check({tag, "_erst_cycles"}, 32'(rst_low_cnt - r0), exp_done ? 32'(ERST) : 32'(ERST + 1));
      check({tag, "_start_cycles"}, 32'(start_cnt - s0), 32'd1);
      check({tag, "_irq"}, {31'b0, irq}, {31'b0, (m_done | m_to) & m_irq_en});
      if (m_irq_en)
         check({tag, "_irq_delay"}, 32'(irq_cyc - start_cyc), exp_done ? 32'(d + 1) : 32'(lim));
      bus_read(32'h04, exp_read(1), {tag, "_status"});
      bus_read(32'h24, exp_read(9), {tag, "_result"});
      bus_read(32'h2C, exp_read(11), {tag, "_cycles"});
      reg_write(1, 32'h6);
      bus_read(32'h04, exp_read(1), {tag, "_status_w1c"});
      check({tag, "_irq_w1c"}, {31'b0, irq}, 32'd0);
   endtask

   // behavioural engine: done is sticky until eng_rst_n, raised d cycles after eng_start
   initial begin
      eng_done = 0; eng_output_data = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!eng_rst_n) rst_low_cnt++;
         if (eng_start) start_cnt++;
         if (!eng_rst_n) begin
            eng_done = 0; running = 0;
         end else if (eng_start) begin
            running = 1; k = 0; start_cyc = cyc;
         end else if (running) begin
            k++;
            if (eng_delay >= 1 && k == eng_delay) begin
               eng_done = 1; eng_output_data = eng_val; running = 0;
            end
         end
         if (irq && irq_cyc < 0) irq_cyc = cyc;
      end
   end

   // read-data monitor: a read address phase at this edge has its data checked in the next cycle
   initial begin
      bit pend;
      logic [31:0] e;
      string n;
      forever begin
         @(posedge clk);
         pend = hsel && hready && htrans[1] && !hwrite;
         @(negedge clk);
         if (pend) begin
            if (q_exp.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_read: got 0x%0h with no expected entry", hrdata);
            end else begin
               e = q_exp.pop_front(); n = q_nm.pop_front();
               check(n, hrdata, e);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int idx, d, lim;
      bit ok;
      logic [31:0] v;
      int r0, s0;
      rst_n = 0; hsel = 0; haddr = 0; htrans = 0; hwrite = 0; hwdata = 0; hready = 1;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_eng_rst_n", {31'b0, eng_rst_n}, 32'd0);
      check("rst_irq", {31'b0, irq}, 32'd0);
      check("rst_eng_start", {31'b0, eng_start}, 32'd0);
      check("rst_hrdata", hrdata, 32'd0);
      rst_n = 1;
      @(negedge clk);
      check("rel_eng_rst_n", {31'b0, eng_rst_n}, 32'd1);
      check("hreadyout", {30'b0, hresp, hreadyout}, 32'd1);
      bus_read(32'h04, 32'h0, "rst_status");
      bus_read(32'h28, 32'h0100, "rst_tlimit");
      bus_read(32'h00, 32'h0, "rst_ctrl");

      // directed operand writes
      reg_write(2, 32'hA5);
      reg_write(4, 32'hFF);
      reg_write(5, 32'h12345678);
      bus_read(32'h08, 32'hA5, "rd_input");
      bus_read(32'h10, 32'hFF, "rd_mask");
      bus_read(32'h14, 32'h12345678, "rd_w1");
      check("port_input", 32'(eng_input_data), 32'hA5);
      check("port_mask", 32'(eng_mask), 32'hFF);
      check("port_w1", 32'(eng_weights1), 32'h12345678);

      // random register traffic, plus unmapped and read-only offsets
      for (int i = 0; i < 10; i++) begin
         idx = $urandom_range(2, 8);
         v = $urandom;
         reg_write(idx, v);
         bus_read(32'(idx * 4), exp_read(idx), "rand_reg");
      end
      reg_write(12, 32'hFFFF_FFFF);
      reg_write(9, 32'hFFFF_FFFF);
      bus_read(32'h30, 32'h0, "unmapped");
      bus_read(32'h24, exp_read(9), "result_ro");
      check("port_enc", 32'(eng_encoder_output), m_reg[3]);
      check("port_b1", 32'(eng_bias1), m_reg[6]);
      check("port_w2", 32'(eng_weights2), m_reg[7]);
      check("port_b2", 32'(eng_bias2), m_reg[8]);

      // directed jobs
      run_job(7, 8'h3C, "job_noirq");
      reg_write(0, 32'h2);
      run_job(7, 8'h3C, "job_irq");
      reg_write(10, 32'd5);
      run_job(-1, 8'h00, "job_timeout");
      reg_write(10, 32'd6);
      run_job(5, 8'h77, "job_coincident");

      // randomized jobs
      for (int i = 0; i < 8; i++) begin
         reg_write(0, {30'b0, 1'($urandom_range(0, 1)), 1'b0});
         lim = $urandom_range(2, 14);
         d = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(1, 14);
         if (d > 0 && $urandom_range(0, 4) == 0) lim = 0;
         reg_write(10, 32'(lim));
         run_job(d, 8'($urandom_range(0, 255)), "job_rand");
      end

      // abort mid-WAIT with ignored GO and operand write while busy
      reg_write(10, 32'h0100);
      eng_delay = -1;
      r0 = rst_low_cnt; s0 = start_cnt;
      bus_write(32'h0, {30'b0, m_irq_en, 1'b1});
      m_done = 0; m_to = 0;
      wait_start(ok);
      check("abort_start_seen", {31'b0, ok}, 32'd1);
      repeat (2) @(negedge clk);
      bus_read(32'h04, 32'h1, "abort_busy");
      bus_write(32'h08, ~m_reg[2] & wmask(2));
      check("busy_input_hold", 32'(eng_input_data), m_reg[2]);
      bus_write(32'h0, {30'b0, m_irq_en, 1'b1});
      bus_write(32'h0, {29'b0, 1'b1, m_irq_en, 1'b0});
      repeat (6) @(negedge clk);
      check("abort_start_cycles", 32'(start_cnt - s0), 32'd1);
      check("abort_erst_cycles", 32'(rst_low_cnt - r0), 32'(ERST + 1));
      bus_read(32'h04, 32'h0, "abort_status");
      bus_read(32'h08, exp_read(2), "abort_input");
      check("abort_irq", {31'b0, irq}, 32'd0);

      // asynchronous reset during WAIT
      reg_write(0, 32'h2);
      reg_write(7, 32'hCAFE_F00D);
      bus_write(32'h0, 32'h3);
      wait_start(ok);
      check("rst_job_start_seen", {31'b0, ok}, 32'd1);
      repeat (3) @(negedge clk);
      rst_n = 0;
      #1;
      model_reset();
      check("midrst_eng_rst_n", {31'b0, eng_rst_n}, 32'd0);
      check("midrst_w2", 32'(eng_weights2), 32'h0);
      check("midrst_irq", {31'b0, irq}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      check("midrst_rel_eng_rst_n", {31'b0, eng_rst_n}, 32'd1);
      check("midrst_eng_start", {31'b0, eng_start}, 32'd0);
      bus_read(32'h04, 32'h0, "midrst_status");
      bus_read(32'h28, 32'h0100, "midrst_tlimit");
      bus_read(32'h00, 32'h0, "midrst_ctrl");
      bus_read(32'h1C, 32'h0, "midrst_w2_rd");
      bus_read(32'h24, 32'h0, "midrst_result");
      bus_read(32'h2C, 32'h0, "midrst_cycles");

      repeat (4) @(negedge clk);
      if (q_exp.size() != 0) begin
         checks++; failures++;
         $display("FAIL pending_reads: got %0d outstanding expected 0", q_exp.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
